// File: rtl/adc_frame_buffer.sv
// ADC sample capture into ping-pong frame banks, streamed out over valid/ready.
// Optional pre-emphasis filter enabled by defining PRE_EMPHASIS_EN.
module adc_frame_buffer #(
    parameter int DATA_W    = 12,
    parameter int OUT_W     = 16,
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic [OUT_W-1:0]  frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              frame_first,
    output logic              frame_last,
    output logic              overflow,
    output logic [CNT_W-1:0]  overflow_cnt
);

    localparam int PTR_W  = $clog2(FRAME_LEN);
    localparam int ADDR_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

    typedef enum logic {
        W_FILL,
        W_WAIT
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PRIME,
        R_STREAM
    } rstate_t;

    wstate_t            wstate, wstate_n;
    rstate_t            rstate, rstate_n;
    logic               wbank, wbank_n;
    logic               rbank, rbank_n;
    logic [PTR_W-1:0]   wptr, wptr_n;
    logic [PTR_W-1:0]   rptr, rptr_n;
    logic [1:0]         bank_full, bank_full_n;
    logic               wr_en;
    logic               set_full;
    logic               drop;
    logic               release_bank;
    logic [ADDR_W-1:0]  rd_addr;
    logic [OUT_W-1:0]   wr_data;
    logic [OUT_W-1:0]   ram_q;
    logic signed [OUT_W-1:0] conv_s;

    logic [OUT_W-1:0]   mem [2*FRAME_LEN];

    // Offset-binary to two's complement is an MSB flip, then left-justify.
    assign conv_s = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0], {(OUT_W-DATA_W){1'b0}}};

`ifdef PRE_EMPHASIS_EN
    localparam int EW = OUT_W + 2;
    localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(OUT_W-1){1'b0}}};

    logic signed [OUT_W-1:0] hist_s;
    logic signed [EW-1:0]    emph_wide;

    assign emph_wide = EW'(conv_s) - EW'(hist_s) + EW'(hist_s >>> 5);

    always_comb begin
        wr_data = emph_wide[OUT_W-1:0];
        if (emph_wide > SAT_MAX) begin
            wr_data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (emph_wide < SAT_MIN) begin
            wr_data = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // History follows accepted samples only, so dropped samples leave no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_s <= '0;
        end else if (wr_en) begin
            hist_s <= conv_s;
        end
    end
`else
    assign wr_data = conv_s;
`endif

    always_comb begin
        wstate_n = wstate;
        wbank_n  = wbank;
        wptr_n   = wptr;
        wr_en    = 1'b0;
        set_full = 1'b0;
        drop     = 1'b0;
        case (wstate)
            W_FILL: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (wptr == LAST_IDX) begin
                        set_full = 1'b1;
                        wptr_n   = '0;
                        // A release on this same edge frees the other bank in time.
                        if (!bank_full[~wbank] || release_bank) begin
                            wbank_n = ~wbank;
                        end else begin
                            wstate_n = W_WAIT;
                        end
                    end else begin
                        wptr_n = wptr + 1'b1;
                    end
                end
            end
            W_WAIT: begin
                drop = sample_valid;
                if (release_bank) begin
                    wbank_n  = ~wbank;
                    wstate_n = W_FILL;
                end
            end
        endcase
    end

    always_comb begin
        rstate_n     = rstate;
        rbank_n      = rbank;
        rptr_n       = rptr;
        rd_addr      = {rbank, rptr};
        release_bank = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (bank_full[rbank]) begin
                    rstate_n = R_PRIME;
                end
            end
            R_PRIME: begin
                rstate_n = R_STREAM;
            end
            R_STREAM: begin
                if (frame_ready) begin
                    if (rptr == LAST_IDX) begin
                        release_bank = 1'b1;
                        rbank_n      = ~rbank;
                        rptr_n       = '0;
                        rd_addr      = {~rbank, {PTR_W{1'b0}}};
                        if (!bank_full[~rbank]) begin
                            rstate_n = R_IDLE;
                        end
                    end else begin
                        rptr_n  = rptr + 1'b1;
                        rd_addr = {rbank, rptr + 1'b1};
                    end
                end
            end
            default: begin
                rstate_n = R_IDLE;
            end
        endcase
    end

    always_comb begin
        bank_full_n = bank_full;
        if (set_full) begin
            bank_full_n[wbank] = 1'b1;
        end
        if (release_bank) begin
            bank_full_n[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate    <= W_FILL;
            rstate    <= R_IDLE;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            bank_full <= '0;
        end else begin
            wstate    <= wstate_n;
            rstate    <= rstate_n;
            wbank     <= wbank_n;
            rbank     <= rbank_n;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            bank_full <= bank_full_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow     <= 1'b0;
            overflow_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_cnt != {CNT_W{1'b1}}) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

    // Read address always points at the next word to present, so ram_q holds steady under stall.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank, wptr}] <= wr_data;
        end
        ram_q <= mem[rd_addr];
    end

    assign frame_valid = (rstate == R_STREAM);
    assign frame_data  = frame_valid ? ram_q : '0;
    assign frame_first = frame_valid && (rptr == '0);
    assign frame_last  = frame_valid && (rptr == LAST_IDX);

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Randomized directed bench for adc_frame_buffer against a frame-queue reference model.
// Follows PRE_EMPHASIS_EN the same way the design does.
module tb_adc_frame_buffer;

    localparam int DATA_W    = 12;
    localparam int OUT_W     = 16;
    localparam int FRAME_LEN = 256;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              frame_ready = 1'b0;
    logic [OUT_W-1:0]  frame_data;
    logic              frame_valid;
    logic              frame_first;
    logic              frame_last;
    logic              overflow;
    logic [CNT_W-1:0]  overflow_cnt;

    adc_frame_buffer #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .adc_data(adc_data),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_first(frame_first), .frame_last(frame_last),
        .overflow(overflow), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: completed frames queued as flat samples, plus bank bookkeeping.
    int exp_q[$];
    int part[$];
    int full_banks;
    bit waiting;
    int out_idx;
    int drops;
    int prev_s;
    longint cyc = 0;
    longint rise_at = -1;
    logic [OUT_W-1:0] got_data[$];
    logic             got_first[$];

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int model_sample(input int adc);
        int s;
        int y;
        s = (adc - (1 << (DATA_W-1))) * (1 << (OUT_W-DATA_W));
`ifdef PRE_EMPHASIS_EN
        y = s - prev_s + (prev_s >>> 5);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
`else
        y = s;
`endif
        prev_s = s;
        return y & 32'hFFFF;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        part.delete();
        got_data.delete();
        got_first.delete();
        full_banks = 0;
        waiting = 0;
        out_idx = 0;
        drops = 0;
        prev_s = 0;
        rise_at = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        frame_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_output("rst_data", frame_data, 0);
        check_output("rst_valid", frame_valid, 0);
        check_output("rst_first", frame_first, 0);
        check_output("rst_last", frame_last, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_ovf_cnt", overflow_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, check outputs, advance the model across the coming edge.
    task automatic apply_stimulus(input bit sv, input int data, input bit ready);
        bit hs;
        bit rel;
        bit completed;
        int exp_cnt;
        @(negedge clk);
        sample_valid = sv;
        adc_data = data[DATA_W-1:0];
        frame_ready = ready;

        exp_cnt = (drops > 65535) ? 65535 : drops;
        check_output("overflow", overflow, (drops > 0) ? 1 : 0);
        check_output("overflow_cnt", overflow_cnt, exp_cnt);
        if (rise_at >= 0) begin
            if (cyc == rise_at - 1) begin
                check_output("valid_early", frame_valid, 0);
            end else if (cyc == rise_at) begin
                check_output("valid_latency", frame_valid, 1);
                rise_at = -1;
            end
        end
        if (out_idx != 0) check_output("valid_mid_frame", frame_valid, 1);

        hs = 1'b0;
        if (frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_valid", frame_valid, 0);
            end else begin
                check_output("data", frame_data, exp_q[0]);
                check_output("first", frame_first, (out_idx == 0) ? 1 : 0);
                check_output("last", frame_last, (out_idx == FRAME_LEN-1) ? 1 : 0);
                hs = ready;
            end
        end
        if (hs) begin
            got_data.push_back(frame_data);
            got_first.push_back(frame_first);
        end

        rel = hs && (out_idx == FRAME_LEN-1);
        if (hs) begin
            void'(exp_q.pop_front());
            out_idx = (out_idx + 1) % FRAME_LEN;
        end
        completed = 1'b0;
        if (sv) begin
            if (waiting) begin
                drops++;
            end else begin
                part.push_back(model_sample(data));
                if (part.size() == FRAME_LEN) begin
                    if (exp_q.size() == 0) rise_at = cyc + 3;
                    foreach (part[i]) exp_q.push_back(part[i]);
                    part.delete();
                    completed = 1'b1;
                end
            end
        end
        if (waiting) waiting = !rel;
        else if (completed && full_banks == 1 && !rel) waiting = 1'b1;
        full_banks = full_banks + int'(completed) - int'(rel);

        @(posedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (exp_q.size() > 0 && used < budget) begin
            apply_stimulus(1'b0, 0, 1'b1);
            used++;
        end
        check_output("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        model_reset();
        do_reset();

        $display("[TB] T1 reset mid-frame");
        for (int i = 0; i < 100; i++) apply_stimulus(1'b1, $urandom_range(4095, 0), 1'b1);
        do_reset();
        for (int i = 0; i < FRAME_LEN; i++) apply_stimulus(1'b1, $urandom_range(4095, 0), 1'b1);
        drain(600, n);
        repeat (4) apply_stimulus(1'b0, 0, 1'b1);
        check_output("t1_count", got_data.size(), FRAME_LEN);

        $display("[TB] T2 conversion");
        do_reset();
        apply_stimulus(1'b1, 'h000, 1'b1);
        apply_stimulus(1'b1, 'h800, 1'b1);
        apply_stimulus(1'b1, 'hFFF, 1'b1);
        apply_stimulus(1'b1, 'h801, 1'b1);
        for (int i = 4; i < FRAME_LEN; i++) apply_stimulus(1'b1, $urandom_range(4095, 0), 1'b1);
        drain(600, n);
        check_output("t2_count", got_data.size(), FRAME_LEN);
`ifndef PRE_EMPHASIS_EN
        if (got_data.size() >= 4) begin
            check_output("t2_conv0", got_data[0], 'h8000);
            check_output("t2_conv1", got_data[1], 'h0000);
            check_output("t2_conv2", got_data[2], 'h7FF0);
            check_output("t2_conv3", got_data[3], 'h0010);
            check_output("t2_first0", got_first[0], 1);
            check_output("t2_first1", got_first[1], 0);
            check_output("t2_first3", got_first[3], 0);
        end
`endif

        $display("[TB] T3 throughput");
        do_reset();
        for (int i = 0; i < 2*FRAME_LEN; i++) apply_stimulus(1'b1, $urandom_range(4095, 0), 1'b1);
        drain(1000, n);
        check_output("t3_drain_cycles", n, FRAME_LEN + 2);
        check_output("t3_count", got_data.size(), 2*FRAME_LEN);
        check_output("t3_overflow", overflow, 0);

        $display("[TB] T4 backpressure");
        do_reset();
        for (int i = 0; i < 600; i++) apply_stimulus(1'b1, $urandom_range(4095, 0), 1'b0);
        repeat (5) apply_stimulus(1'b0, 0, 1'b0);
        check_output("t4_overflow", overflow, 1);
        check_output("t4_ovf_cnt", overflow_cnt, 88);
        drain(1200, n);
        check_output("t4_count", got_data.size(), 2*FRAME_LEN);

        $display("[TB] T5 random ready");
        do_reset();
        for (int i = 0; i < 4*FRAME_LEN; i++) begin
            apply_stimulus(1'b1, $urandom_range(4095, 0), 1'($urandom_range(1, 0)));
            repeat (3) apply_stimulus(1'b0, 0, 1'($urandom_range(1, 0)));
        end
        drain(3000, n);
        check_output("t5_ovf_cnt", overflow_cnt, 0);
        check_output("t5_count", got_data.size(), 4*FRAME_LEN);

`ifdef PRE_EMPHASIS_EN
        $display("[TB] T6 pre-emphasis");
        do_reset();
        apply_stimulus(1'b1, 'hFFF, 1'b1);
        apply_stimulus(1'b1, 'hFFF, 1'b1);
        apply_stimulus(1'b1, 'h000, 1'b1);
        apply_stimulus(1'b1, 'hFFF, 1'b1);
        for (int i = 4; i < FRAME_LEN; i++) apply_stimulus(1'b1, $urandom_range(4095, 0), 1'b1);
        drain(600, n);
        check_output("t6_count", got_data.size(), FRAME_LEN);
        if (got_data.size() >= 4) begin
            check_output("t6_y0", got_data[0], 'h7FF0);
            check_output("t6_y1", got_data[1], 'h03FF);
            check_output("t6_y2", got_data[2], 'h8000);
            check_output("t6_y3", got_data[3], 'h7FFF);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the test sequence finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
